fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 21 ++
 rtl/fetch_stage_ifid_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch stage and its IF/ID register.
//   NOP_INSTR     - instruction word that encodes an IF/ID bubble
//   fetch_state_t - fetch FSM states (FETCH, WAIT)
//   OP_J, OP_BEQ  - opcode field values of jump and branch-equal
//   sat_inc8      - 8-bit increment that sticks at 8'hFF
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OP_J      = 6'h02;
    localparam logic [5:0]  OP_BEQ    = 6'h04;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush > hold > load > bubble priority.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   flush_i      - squash the register to a bubble (redirect)
//   hold_i       - keep the current contents (decode stall)
//   load_i       - capture instr_i / pcplus4_i as a valid instruction
//   instr_i      - fetched instruction word
//   pcplus4_i    - PC+4 of the fetched instruction
//   instr_o, pcplus4_o, valid_o - registered IF/ID contents
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d   = NOP_INSTR;
        pcplus4_d = 32'h0;
        valid_d   = 1'b0;
        if (flush_i) begin
            // bubble (defaults)
        end else if (hold_i) begin
            instr_d   = instr_q;
            pcplus4_d = pcplus4_q;
            valid_d   = valid_q;
        end else if (load_i) begin
            instr_d   = instr_i;
            pcplus4_d = pcplus4_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Holds pcF, talks to an
// instruction memory with a per-cycle valid, resolves decode redirects
// (branch / jump) and feeds the IF/ID register.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   imem_addr             - fetch address (pcF)
//   imem_rdata/imem_valid - returned word and its valid for imem_addr
//   stallF, stallD        - hazard-unit holds of pcF and IF/ID
//   pcsrcD, pcbranchD     - taken branch and its target
//   jumpD                 - jump in decode (target from instrD)
//   instrD, pcplus4D, validD, opD, functD - IF/ID outputs
//   stall_cnt, flush_cnt  - perf counters, only with FETCH_PERF_CNT_EN
// Optional feature macro: FETCH_PERF_CNT_EN
//
// state | meaning
// FETCH | word expected this cycle
// WAIT  | memory has not answered; pcF held, wait counter running
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        pcsrcD,
    input  logic [31:0] pcbranchD,
    input  logic        jumpD,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    output logic [5:0]  opD,
    output logic [5:0]  functD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4, jump_target, redirect_target;
    fetch_state_t state_q, state_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic         redirect, accept;

    // Control from decode only counts when decode holds a real instruction.
    assign redirect        = (pcsrcD | jumpD) & validD;
    assign pc_plus4        = pc_q + 32'd4;
    assign jump_target     = {pcplus4D[31:28], instrD[25:0], 2'b00};
    assign redirect_target = jumpD ? jump_target : pcbranchD;
    assign accept          = imem_valid & ~stallF;

    always_comb begin
        pc_d = pc_q;
        if (stallF)          pc_d = pc_q;
        else if (redirect)   pc_d = redirect_target;
        else if (imem_valid) pc_d = pc_plus4;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (!imem_valid && !stallF) state_d = WAIT;
            WAIT:  if (imem_valid || redirect) state_d = FETCH;
            default: state_d = FETCH;
        endcase
        // Counter tracks the cycle being entered: each WAIT cycle adds one
        // (the entry into WAIT included), any FETCH cycle reads zero.
        wait_cnt_d = (state_d == WAIT) ? sat_inc8(wait_cnt_q) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            state_q    <= FETCH;
            wait_cnt_q <= 8'h00;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    ifid_reg u_ifid (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (redirect),
        .hold_i    (stallD),
        .load_i    (accept),
        .instr_i   (imem_rdata),
        .pcplus4_i (pc_plus4),
        .instr_o   (instrD),
        .pcplus4_o (pcplus4D),
        .valid_o   (validD)
    );

    assign imem_addr = pc_q;
    assign opD       = instrD[31:26];
    assign functD    = instrD[5:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'h0, stallF};
            flush_cnt_q <= flush_cnt_q + {31'h0, redirect};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic for fetch_stage,
// every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_stage;
    import mips_pkg::*;

    logic        clk;
    logic        r_reset, r_imem_valid, r_stallF, r_stallD, r_pcsrc, r_jump;
    logic [31:0] r_rdata, r_pcbranch;
    logic [31:0] imem_addr, instrD, pcplus4D;
    logic        validD;
    logic [5:0]  opD, functD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_stall, m_flush;
    logic        m_valid, m_waiting;
    int          m_wcnt;
    // model next values
    logic [31:0] n_pc, n_instr, n_pc4, n_stall, n_flush;
    logic        n_valid, n_waiting;
    int          n_wcnt;

    fetch_stage dut (
        .clk        (clk),
        .reset      (r_reset),
        .imem_addr  (imem_addr),
        .imem_rdata (r_rdata),
        .imem_valid (r_imem_valid),
        .stallF     (r_stallF),
        .stallD     (r_stallD),
        .pcsrcD     (r_pcsrc),
        .pcbranchD  (r_pcbranch),
        .jumpD      (r_jump),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD),
        .opD        (opD),
        .functD     (functD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Next model values from the current model state and the driven inputs.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        if (r_reset) begin
            n_pc = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
            n_waiting = 1'b0; n_wcnt = 0; n_stall = 32'h0; n_flush = 32'h0;
            return;
        end
        redir = m_valid && (r_pcsrc || r_jump);
        tgt   = r_jump ? {m_pc4[31:28], m_instr[25:0], 2'b00} : r_pcbranch;
        if (r_stallF)          n_pc = m_pc;
        else if (redir)        n_pc = tgt;
        else if (r_imem_valid) n_pc = m_pc + 32'd4;
        else                   n_pc = m_pc;
        if (!m_waiting) n_waiting = !r_imem_valid && !r_stallF;
        else            n_waiting = !(r_imem_valid || redir);
        n_wcnt = n_waiting ? ((m_wcnt >= 255) ? 255 : m_wcnt + 1) : 0;
        if (redir) begin
            n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
        end else if (r_stallD) begin
            n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
        end else if (r_imem_valid && !r_stallF) begin
            n_instr = r_rdata; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
        end else begin
            n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
        end
        n_stall = m_stall + (r_stallF ? 32'd1 : 32'd0);
        n_flush = m_flush + (redir ? 32'd1 : 32'd0);
    endtask

    task automatic compare_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("instrD", instrD, m_instr);
        chk("pcplus4D", pcplus4D, m_pc4);
        chk("validD", {31'h0, validD}, {31'h0, m_valid});
        chk("opD", {26'h0, opD}, {26'h0, m_instr[31:26]});
        chk("functD", {26'h0, functD}, {26'h0, m_instr[5:0]});
        chk("state", 32'(dut.state_q), {31'h0, m_waiting});
        chk("wait_cnt", {24'h0, dut.wait_cnt_q}, 32'(m_wcnt));
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
        m_waiting = n_waiting; m_wcnt = n_wcnt; m_stall = n_stall; m_flush = n_flush;
        compare_all();
    endtask

    task automatic set_idle();
        r_reset = 1'b0; r_imem_valid = 1'b0; r_stallF = 1'b0; r_stallD = 1'b0;
        r_pcsrc = 1'b0; r_jump = 1'b0; r_rdata = 32'h0; r_pcbranch = 32'h0;
    endtask

    task automatic do_reset();
        set_idle();
        r_reset = 1'b1;
        cycle();
        r_reset = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w);
        set_idle();
        r_imem_valid = 1'b1;
        r_rdata = w;
        cycle();
        set_idle();
    endtask

    initial begin
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_waiting = 1'b0; m_wcnt = 0; m_stall = 32'h0; m_flush = 32'h0;

        // reset state
        do_reset();
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, validD}, 32'h0);
        chk("rst_instr", instrD, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'h0);

        // three straight fetches
        feed(32'h2008_0005);
        feed(32'h2009_0003);
        feed(32'h0109_5020);
        chk("seq_pc", imem_addr, 32'h0000_000C);
        chk("seq_instr", instrD, 32'h0109_5020);
        chk("seq_pc4", pcplus4D, 32'h0000_000C);
        chk("seq_valid", {31'h0, validD}, 32'h1);

        // taken BEQ in decode
        feed({OP_BEQ, 5'd8, 5'd9, 16'd3});
        chk("beq_op", {26'h0, opD}, {26'h0, OP_BEQ});
        r_pcsrc = 1'b1; r_pcbranch = 32'h0000_0040; r_imem_valid = 1'b1; r_rdata = 32'hDEAD_BEEF;
        cycle();
        set_idle();
        chk("beq_pc", imem_addr, 32'h0000_0040);
        chk("beq_valid", {31'h0, validD}, 32'h0);
        chk("beq_instr", instrD, 32'h0);

        // jump in decode, jump target wins over branch
        do_reset();
        feed(32'h2008_0005);
        feed({OP_J, 26'h10});
        chk("j_instr", instrD, 32'h0800_0010);
        chk("j_pc4", pcplus4D, 32'h0000_0008);
        r_jump = 1'b1; r_pcsrc = 1'b1; r_pcbranch = 32'h0000_0100; r_imem_valid = 1'b1; r_rdata = 32'h1;
        cycle();
        set_idle();
        chk("j_pc", imem_addr, 32'h0000_0040);
        chk("j_valid", {31'h0, validD}, 32'h0);
        chk("j_bubble", instrD, 32'h0);

        // memory wait at pcF=0x10
        do_reset();
        for (int i = 0; i < 4; i++) feed($urandom);
        for (int i = 0; i < 4; i++) begin
            set_idle();
            cycle();
            chk("wait_pc", imem_addr, 32'h0000_0010);
            chk("wait_valid", {31'h0, validD}, 32'h0);
            chk("wait_state", 32'(dut.state_q), 32'h1);
            chk("wait_cnt_lit", {24'h0, dut.wait_cnt_q}, 32'(i + 1));
        end
        feed(32'hAABB_CCDD);
        chk("rec_instr", instrD, 32'hAABB_CCDD);
        chk("rec_cnt", {24'h0, dut.wait_cnt_q}, 32'h0);
        chk("rec_pc", imem_addr, 32'h0000_0014);

        // full stall with memory ready
        for (int i = 0; i < 2; i++) begin
            set_idle();
            r_stallF = 1'b1; r_stallD = 1'b1; r_imem_valid = 1'b1; r_rdata = 32'h1234_5678;
            cycle();
        end
        set_idle();
        chk("stall_pc", imem_addr, 32'h0000_0014);
        chk("stall_instr", instrD, 32'hAABB_CCDD);
        chk("stall_valid", {31'h0, validD}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt_lit", stall_cnt, 32'd2);
`endif

        // wrap-around, then reset from WAIT with everything else asserted
        r_pcsrc = 1'b1; r_pcbranch = 32'hFFFF_FFFC;
        cycle();
        set_idle();
        chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        feed(32'h1111_1111);
        chk("wrap_pc", imem_addr, 32'h0000_0000);
        chk("wrap_pc4", pcplus4D, 32'h0000_0000);
        feed(32'h2222_2222);
        cycle();
        cycle();
        chk("prerst_state", 32'(dut.state_q), 32'h1);
        set_idle();
        r_reset = 1'b1; r_stallF = 1'b1; r_stallD = 1'b1; r_pcsrc = 1'b1; r_imem_valid = 1'b1;
        cycle();
        set_idle();
        chk("wrst_pc", imem_addr, 32'h0);
        chk("wrst_state", 32'(dut.state_q), 32'h0);
        chk("wrst_valid", {31'h0, validD}, 32'h0);

        // wait counter saturation
        for (int i = 0; i < 260; i++) cycle();
        chk("wait_sat", {24'h0, dut.wait_cnt_q}, 32'h0000_00FF);
        feed(32'h3333_3333);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r_reset      = ($urandom_range(0, 99) == 0);
            r_imem_valid = ($urandom_range(0, 9) < 7);
            r_stallF     = ($urandom_range(0, 9) < 2);
            r_stallD     = ($urandom_range(0, 9) < 2);
            r_pcsrc      = ($urandom_range(0, 9) < 1);
            r_jump       = ($urandom_range(0, 9) < 1);
            r_rdata      = $urandom;
            r_pcbranch   = $urandom & 32'hFFFF_FFFC;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
